// File: rtl/snake_pkg.sv
// Shared snake definitions: run states, one-hot directions
// and the opposite-direction helper.
package snake_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_OVER  = 2'd3
    } state_e;

    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    function automatic logic [3:0] opposite(input logic [3:0] d);
        return {d[2], d[3], d[0], d[1]};
    endfunction

endpackage

// File: rtl/snake_game_sequencer_if.sv
// Button/game-logic bundle of the snake run-control sequencer.
// slave = sequencer side, master = buttons plus game logic.
interface snake_game_sequencer_if;
    logic [3:0]  i_Buttons;
    logic        i_Start;
    logic        i_Kill;
    logic [15:0] i_Score;
    logic        o_Tick;
    logic [3:0]  o_Direction;
    logic        o_GameRst;
    logic [1:0]  o_State;

    modport master (
        output i_Buttons, i_Start, i_Kill, i_Score,
        input  o_Tick, o_Direction, o_GameRst, o_State
    );

    modport slave (
        input  i_Buttons, i_Start, i_Kill, i_Score,
        output o_Tick, o_Direction, o_GameRst, o_State
    );
endinterface

// File: rtl/snake_dir_queue.sv
// Two-entry direction FIFO that drops duplicate and reversing
// presses relative to the tail (or the applied direction).
module snake_dir_queue
    import snake_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       push_i,
    input  logic [3:0] dir_i,
    input  logic       pop_i,
    input  logic [3:0] cur_i,
    output logic [3:0] head_o,
    output logic [1:0] count_o
);

    logic [3:0] e0_q, e1_q, e0_d, e1_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] ref_dir;
    logic       accept;

    always_comb begin
        ref_dir = cur_i;
        if (cnt_q == 2'd1) ref_dir = e0_q;
        if (cnt_q == 2'd2) ref_dir = e1_q;
        accept = push_i && (cnt_q != 2'd2)
              && (dir_i != ref_dir)
              && (dir_i != opposite(ref_dir));
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        // Reference and capacity are judged before the pop
        if (pop_i && cnt_q != 2'd0) begin
            e0_d  = e1_q;
            cnt_d = cnt_q - 2'd1;
        end
        if (accept) begin
            if (cnt_d == 2'd0) e0_d = dir_i;
            else               e1_d = dir_i;
            cnt_d = cnt_d + 2'd1;
        end
        if (clear_i) cnt_d = 2'd0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            e0_q  <= DIR_RIGHT;
            e1_q  <= DIR_RIGHT;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_o  = e0_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/snake_game_sequencer.sv
// Snake run-control: FSM, edge detect, move-tick timer, game reset.
// SNAKE_SPEEDUP_EN shortens the move period as the score grows.
module snake_game_sequencer
    import snake_pkg::*;
#(
    parameter int TICK_DIV    = 5323500,
    parameter int MIN_DIV     = 2661750,
    parameter int SPEED_STEP  = 133088,
    parameter int SCORE_SHIFT = 2
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    snake_game_sequencer_if.slave bus
);

    localparam int CW = $clog2(TICK_DIV + 1);

    state_e          state_q;
    logic [3:0]      btn_q, press_q, rise;
    logic            start_q, start_edge_q;
    logic [CW-1:0]   cnt_q, period_q, new_period;
    logic            tick_q, gamerst_q;
    logic [3:0]      dir_q, q_head;
    logic [1:0]      q_count;
    logic            at_end, q_push, q_pop, q_clear;

    assign rise   = bus.i_Buttons & ~btn_q;
    assign at_end = cnt_q >= (period_q - 1'b1);
    assign q_pop  = (state_q == S_RUN) && !bus.i_Kill
                 && !start_edge_q && at_end;
    assign q_push = (state_q == S_RUN) && (|press_q);
    assign q_clear = start_edge_q
                  && (state_q == S_IDLE || state_q == S_OVER);

`ifdef SNAKE_SPEEDUP_EN
    logic [31:0] reduce;
    always_comb begin
        reduce = 32'(bus.i_Score >> SCORE_SHIFT) * 32'(SPEED_STEP);
        // Clamp also covers reduce > TICK_DIV (unsigned underflow)
        if (reduce >= 32'(TICK_DIV)
            || (32'(TICK_DIV) - reduce) < 32'(MIN_DIV))
            new_period = CW'(MIN_DIV);
        else
            new_period = CW'(32'(TICK_DIV) - reduce);
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{bus.i_Score, MIN_DIV, SPEED_STEP, SCORE_SHIFT};
    assign new_period = CW'(TICK_DIV);
`endif

    snake_dir_queue u_queue (
        .clk_i   (i_Clk),
        .rst_ni  (i_Rst),
        .clear_i (q_clear),
        .push_i  (q_push),
        .dir_i   (press_q),
        .pop_i   (q_pop),
        .cur_i   (dir_q),
        .head_o  (q_head),
        .count_o (q_count)
    );

    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            state_q      <= S_IDLE;
            btn_q        <= '0;
            press_q      <= '0;
            start_q      <= 1'b0;
            start_edge_q <= 1'b0;
            cnt_q        <= '0;
            period_q     <= CW'(TICK_DIV);
            tick_q       <= 1'b0;
            gamerst_q    <= 1'b0;
            dir_q        <= DIR_RIGHT;
        end else begin
            btn_q        <= bus.i_Buttons;
            start_q      <= bus.i_Start;
            start_edge_q <= bus.i_Start & ~start_q;
            press_q      <= $onehot(rise) ? rise : 4'b0000;
            tick_q       <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    gamerst_q <= 1'b0;
                    if (start_edge_q) begin
                        state_q   <= S_RUN;
                        gamerst_q <= 1'b1;
                        cnt_q     <= '0;
                        period_q  <= new_period;
                        dir_q     <= DIR_RIGHT;
                    end
                end
                S_RUN: begin
                    if (bus.i_Kill) begin
                        state_q <= S_OVER;
                    end else if (start_edge_q) begin
                        state_q <= S_PAUSE;
                    end else if (at_end) begin
                        tick_q   <= 1'b1;
                        cnt_q    <= '0;
                        period_q <= new_period;
                        if (q_count != 2'd0) dir_q <= q_head;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (start_edge_q) state_q <= S_RUN;
                end
                S_OVER: begin
                    if (start_edge_q) begin
                        state_q   <= S_IDLE;
                        gamerst_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.o_Tick      = tick_q;
    assign bus.o_Direction = dir_q;
    assign bus.o_GameRst   = gamerst_q;
    assign bus.o_State     = state_q;

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Scoreboard bench for snake_game_sequencer (TICK_DIV=8, MIN_DIV=4).
// Optional speed-up scenario follows SNAKE_SPEEDUP_EN.
module tb_snake_game_sequencer;

    typedef struct {
        bit         is_st;
        int         cyc;
        logic [3:0] val;
        logic       gr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    bit   mon_en = 1'b0;
    logic [1:0] prev_st = 2'd0;

    snake_game_sequencer_if bus ();

    snake_game_sequencer #(
        .TICK_DIV    (8),
        .MIN_DIV     (4),
        .SPEED_STEP  (1),
        .SCORE_SHIFT (1)
    ) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void expect_ev(input bit s, input int c,
                                      input logic [3:0] v,
                                      input logic g);
        exp_t e;
        e.is_st = s;
        e.cyc   = c;
        e.val   = v;
        e.gr    = g;
        sb.push_back(e);
    endfunction

    task automatic take(input bit s, input logic [3:0] v,
                        input logic g);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: st=%0d cyc=%0d val=%b",
                     s, cyc, v);
        end else begin
            e = sb.pop_front();
            if (e.is_st != s || e.cyc != cyc || e.val != v
                || (s && e.gr != g)) begin
                errors++;
                $display({"FAIL event: got st=%0d cyc=%0d val=%b gr=%b,",
                          " want st=%0d cyc=%0d val=%b gr=%b"},
                         s, cyc, v, g, e.is_st, e.cyc, e.val, e.gr);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.o_State != prev_st) begin
                take(1'b1, {2'b00, bus.o_State}, bus.o_GameRst);
                prev_st = bus.o_State;
            end
            if (bus.o_Tick) take(1'b0, bus.o_Direction, 1'b0);
        end
    end

    task automatic at(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [3:0] got,
                       input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", nm, got, want);
        end
    endtask

    initial begin
        int c;
        bus.i_Buttons = 4'b0;
        bus.i_Start   = 1'b0;
        bus.i_Kill    = 1'b0;
        bus.i_Score   = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_state", {2'b00, bus.o_State}, 4'd0);
        chk("rst_tick", {3'b000, bus.o_Tick}, 4'd0);
        chk("rst_dir", bus.o_Direction, 4'b1000);
        chk("rst_gamerst", {3'b000, bus.o_GameRst}, 4'd0);
        rst = 1'b1;
        @(negedge clk);
        prev_st = bus.o_State;
        mon_en  = 1'b1;
        c = cyc;

        // start, then up/left/down inside the first period
        bus.i_Start = 1'b1;
        expect_ev(1, c + 2, 4'd1, 1'b1);
        expect_ev(0, c + 10, 4'b0001, 1'b0);
        expect_ev(0, c + 18, 4'b0100, 1'b0);
        expect_ev(0, c + 26, 4'b0100, 1'b0);
        at(c + 1);  bus.i_Start = 1'b0;
        at(c + 3);  bus.i_Buttons = 4'b0001;
        at(c + 4);  bus.i_Buttons = 4'b0000;
        at(c + 5);  bus.i_Buttons = 4'b0100;
        at(c + 6);  bus.i_Buttons = 4'b0000;
        at(c + 7);  bus.i_Buttons = 4'b0010;
        at(c + 8);  bus.i_Buttons = 4'b0000;

        // reversal and two-bit press, both dropped
        at(c + 27); bus.i_Buttons = 4'b1000;
        expect_ev(0, c + 34, 4'b0100, 1'b0);
        at(c + 28); bus.i_Buttons = 4'b0000;
        at(c + 29); bus.i_Buttons = 4'b0011;
        at(c + 30); bus.i_Buttons = 4'b0000;

        // pause at count 5; press and kill ignored while paused
        at(c + 38); bus.i_Start = 1'b1;
        expect_ev(1, c + 40, 4'd2, 1'b1);
        at(c + 39); bus.i_Start = 1'b0;
        at(c + 45); bus.i_Buttons = 4'b0001;
        at(c + 46); bus.i_Buttons = 4'b0000; bus.i_Kill = 1'b1;
        at(c + 47); bus.i_Kill = 1'b0;
        at(c + 50); bus.i_Start = 1'b1;
        expect_ev(1, c + 52, 4'd1, 1'b1);
        expect_ev(0, c + 55, 4'b0100, 1'b0);
        at(c + 51); bus.i_Start = 1'b0;

        // kill on a would-be tick, then back to idle and restart
        at(c + 62); bus.i_Kill = 1'b1;
        expect_ev(1, c + 63, 4'd3, 1'b1);
        at(c + 64); bus.i_Kill = 1'b0;
        at(c + 66); bus.i_Start = 1'b1;
        expect_ev(1, c + 68, 4'd0, 1'b0);
        at(c + 67); bus.i_Start = 1'b0;
        at(c + 70); bus.i_Start = 1'b1;
        expect_ev(1, c + 72, 4'd1, 1'b1);
        at(c + 71); bus.i_Start = 1'b0;
        at(c + 73); bus.i_Buttons = 4'b0010;
        expect_ev(0, c + 80, 4'b0010, 1'b0);
        at(c + 74); bus.i_Buttons = 4'b0000;

`ifdef SNAKE_SPEEDUP_EN
        expect_ev(0, c + 88, 4'b0010, 1'b0);
        expect_ev(0, c + 93, 4'b0010, 1'b0);
        expect_ev(0, c + 98, 4'b0010, 1'b0);
        expect_ev(0, c + 102, 4'b0010, 1'b0);
        at(c + 81); bus.i_Score = 16'd6;
        at(c + 94); bus.i_Score = 16'd20;
`else
        expect_ev(0, c + 88, 4'b0010, 1'b0);
        expect_ev(0, c + 96, 4'b0010, 1'b0);
`endif

        // reset mid-game
        at(c + 103); rst = 1'b0;
        expect_ev(1, c + 104, 4'd0, 1'b0);
        at(c + 106); rst = 1'b1;
        chk("midrst_dir", bus.o_Direction, 4'b1000);
        chk("midrst_gamerst", {3'b000, bus.o_GameRst}, 4'd0);
        chk("midrst_tick", {3'b000, bus.o_Tick}, 4'd0);
        at(c + 112);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_events: got %0d left want 0",
                     sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
